fft_frame_reader: RTL and testbench

- Downstream consumer of the 16-bit, 8192-deep FFT sample FIFO (one clock).
- Waits until the FIFO holds a full frame of FRAME_LEN samples, then drains exactly FRAME_LEN samples.
- Emits them as an AXI4-Stream frame to the FFT core: real part from the FIFO, imaginary part zero, tlast on the final sample.
- Absorbs FFT backpressure with a 2-entry output buffer that covers the FIFO's 1-cycle read latency.

---
 rtl/fft_frame_reader.sv | 139 +++++++++++++
 tb/tb_fft_frame_reader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_reader.sv
// Drains one FRAME_LEN-sample frame from the FFT sample FIFO once a whole frame is buffered,
// and streams it to the FFT core over AXI4-Stream as {imag = 0, real = sample}.
module fft_frame_reader #(
   parameter int DATA_WIDTH  = 16,
   parameter int LEVEL_WIDTH = 14,
   parameter int FRAME_LEN   = 1024,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   output logic                    fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
   input  logic                    fifo_rd_empty,
   input  logic [LEVEL_WIDTH-1:0]  fifo_rd_water_level,
   output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic                    frame_done,
   output logic [CNT_WIDTH-1:0]    frame_cnt,
   output logic                    underrun,
   output logic [1:0]              dbg_state
);

   localparam int RC_W = $clog2(FRAME_LEN) + 1;
   localparam int BC_W = $clog2(FRAME_LEN);
   localparam logic [LEVEL_WIDTH-1:0] LVL_FRAME = LEVEL_WIDTH'(FRAME_LEN);
   localparam logic [RC_W-1:0]        RD_FULL   = RC_W'(FRAME_LEN);
   localparam logic [RC_W-1:0]        RD_LAST   = RC_W'(FRAME_LEN - 1);
   localparam logic [BC_W-1:0]        BEAT_LAST = BC_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_FLUSH = 2'd2} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [RC_W-1:0]       r_rd_cnt;
   logic [BC_W-1:0]       r_beat_cnt;
   logic                  r_inflight;
   logic [1:0]            r_occ;
   logic [DATA_WIDTH-1:0] r_buf0;
   logic [DATA_WIDTH-1:0] r_buf1;
   logic [CNT_WIDTH-1:0]  r_frame_cnt;
   logic                  r_underrun;
   logic                  w_pop;
   logic                  w_last_xfer;
   logic                  w_credit;

   // AXI-S: a beat transfers when tvalid && tready at the clock edge; while tvalid is high
   // and tready low, tdata/tlast/tvalid hold because they come straight from r_buf0/r_occ/r_beat_cnt.
   assign m_axis_tvalid = (r_occ != 2'd0);
   assign m_axis_tdata  = {{DATA_WIDTH{1'b0}}, r_buf0};
   assign m_axis_tlast  = m_axis_tvalid && (r_beat_cnt == BEAT_LAST);
   assign w_pop         = m_axis_tvalid && m_axis_tready;
   assign w_last_xfer   = w_pop && m_axis_tlast;
   assign frame_done    = w_last_xfer;
   assign frame_cnt     = r_frame_cnt;
   assign underrun      = r_underrun;
   assign dbg_state     = r_state;
   // Buffer slots already claimed (stored + still in flight from the FIFO) must stay below two.
   assign w_credit      = (r_occ == 2'd0) || ((r_occ == 2'd1) && !r_inflight);

   always_comb begin
      w_state_nxt = r_state;
      fifo_rd_en  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (en && (fifo_rd_water_level >= LVL_FRAME)) w_state_nxt = S_STREAM;
         end
         S_STREAM: begin
            fifo_rd_en = (r_rd_cnt < RD_FULL) && !fifo_rd_empty && (w_credit || w_pop);
            if (fifo_rd_en && (r_rd_cnt == RD_LAST)) w_state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            if (w_last_xfer) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rd_cnt    <= '0;
         r_inflight  <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= fifo_rd_en;
         if (r_state == S_IDLE) r_rd_cnt <= '0;
         else if (fifo_rd_en)   r_rd_cnt <= r_rd_cnt + 1'b1;
         if ((r_state == S_STREAM) && (r_rd_cnt < RD_FULL) && fifo_rd_empty) r_underrun <= 1'b1;
      end
   end

   // Two-entry buffer in FIFO order; r_buf0 is always the head presented on the stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ  <= 2'd0;
         r_buf0 <= '0;
         r_buf1 <= '0;
      end else begin
         case ({r_inflight, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_buf0 <= fifo_rd_data;
               else               r_buf1 <= fifo_rd_data;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_buf0 <= r_buf1;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_buf0 <= fifo_rd_data;
               end else begin
                  r_buf0 <= r_buf1;
                  r_buf1 <= fifo_rd_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat_cnt  <= '0;
         r_frame_cnt <= '0;
      end else begin
         if (w_pop) begin
            if (m_axis_tlast) r_beat_cnt <= '0;
            else              r_beat_cnt <= r_beat_cnt + 1'b1;
         end
         if (w_last_xfer) r_frame_cnt <= r_frame_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fft_frame_reader.sv
// Bench for fft_frame_reader: queue-based FIFO model, expected-sample scoreboard checked every cycle,
// and directed scenarios for level gating, throughput, backpressure, en, underrun and reset.
module tb_fft_frame_reader;
  localparam int FRAME_LEN = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data = '0;
  logic        fifo_rd_empty = 1'b1;
  logic [13:0] fifo_rd_water_level = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        underrun;
  logic [1:0]  dbg_state;

  fft_frame_reader #(.DATA_WIDTH(16), .LEVEL_WIDTH(14), .FRAME_LEN(FRAME_LEN), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(fifo_rd_water_level),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .underrun(underrun), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // environment and scoreboard state
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_frames = 0;
  int beat_idx = 0;
  int rd_in_frame = 0;
  int rd_total = 0;
  int beats_total = 0;
  int done_cnt = 0;
  bit seen_first = 0;
  bit last_rd_en = 0;
  bit force_empty = 0;
  bit rand_ready = 0;
  bit prev_stall = 0;
  logic [31:0] prev_tdata = '0;
  logic        prev_tlast = 1'b0;
  logic [31:0] first_data = '0;
  logic [31:0] last_data = '0;
  int first_tv_c[8];
  int first_rd_c[8];
  int tlast_c[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flags();
    fifo_rd_empty       = force_empty || (fifo_q.size() == 0);
    fifo_rd_water_level = 14'(fifo_q.size());
  endtask

  task automatic push_ramp(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + 16'(i));
      exp_q.push_back(base + 16'(i));
    end
    flags();
  endtask

  // scoreboard / compare: runs at the falling edge, when all DUT outputs are settled
  task automatic monitor();
    bit          xfer;
    bit          exp_last;
    logic [15:0] exp_s;
    if (rst) begin
      last_rd_en = 0;
      prev_stall = 0;
      return;
    end
    cyc++;
    chk("frame_cnt", 32'(frame_cnt), exp_frames);
    chk("occupancy_le_2", 32'((rd_total - beats_total) <= 2), 1);
    if (prev_stall) begin
      chk("stall_tvalid", 32'(m_axis_tvalid), 1);
      chk("stall_tdata", m_axis_tdata, prev_tdata);
      chk("stall_tlast", 32'(m_axis_tlast), 32'(prev_tlast));
    end
    if (fifo_rd_en) begin
      chk("rd_while_empty", 32'(fifo_rd_empty), 0);
      chk("rd_within_frame", 32'(rd_in_frame < FRAME_LEN), 1);
      if (rd_in_frame == 0) first_rd_c[exp_frames % 8] = cyc;
      rd_in_frame++;
      rd_total++;
    end
    if (m_axis_tvalid && !seen_first) begin
      first_tv_c[exp_frames % 8] = cyc;
      seen_first = 1;
    end
    if (frame_done) done_cnt++;
    xfer = m_axis_tvalid && m_axis_tready;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        chk("beat_expected", 0, 1);
      end else begin
        exp_s = exp_q.pop_front();
        chk("tdata", m_axis_tdata, {16'h0000, exp_s});
      end
      exp_last = (beat_idx == FRAME_LEN - 1);
      chk("tlast", 32'(m_axis_tlast), 32'(exp_last));
      chk("frame_done", 32'(frame_done), 32'(exp_last));
      if (beat_idx == 0) first_data = m_axis_tdata;
      beats_total++;
      if (exp_last) begin
        last_data = m_axis_tdata;
        tlast_c[exp_frames % 8] = cyc;
        exp_frames++;
        beat_idx = 0;
        rd_in_frame = 0;
        seen_first = 0;
      end else begin
        beat_idx++;
      end
    end else begin
      chk("frame_done_quiet", 32'(frame_done), 0);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_tdata = m_axis_tdata;
    prev_tlast = m_axis_tlast;
    last_rd_en = fifo_rd_en;
  endtask

  // FIFO model: data for a read appears the cycle after fifo_rd_en
  task automatic env();
    if (last_rd_en) begin
      if (fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
      else                   fifo_rd_data = 16'hDEAD;
    end
    if (rand_ready) m_axis_tready = ($urandom_range(0, 9) < 3);
    flags();
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    env();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (exp_frames < n && k < budget) begin
      step();
      k++;
    end
    chk("frames_reached", exp_frames, n);
  endtask

  task automatic wait_beat(input int b, input int budget);
    int k = 0;
    while (beat_idx < b && k < budget) begin
      step();
      k++;
    end
    chk("beat_reached", 32'(beat_idx >= b), 1);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
    chk({tag, "_tdata"}, m_axis_tdata, 0);
    chk({tag, "_tlast"}, 32'(m_axis_tlast), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, "_underrun"}, 32'(underrun), 0);
  endtask

  initial begin
    int rd_base;
    int done_base;
    int d_cyc;

    // reset state
    #2 rst = 1'b1;
    #1 chk_zero_outputs("reset");
    repeat (3) step();
    rst = 1'b0;

    // level gating: 1023 samples never start a frame
    en = 1'b1;
    m_axis_tready = 1'b1;
    push_ramp(1023, 16'h0000);
    rd_base = rd_total;
    repeat (50) step();
    chk("gated_no_reads", rd_total - rd_base, 0);
    push_ramp(1, 16'd1023);
    wait_frames(1, 3000);
    step();
    chk("t1_frame_cnt", 32'(frame_cnt), 1);
    chk("t1_first_data", first_data, 32'h0000_0000);
    chk("t1_last_data", last_data, 32'h0000_03FF);
    chk("t1_done_pulses", done_cnt, 1);
    repeat (3) step();

    // full throughput, two back-to-back frames
    push_ramp(2048, 16'h1000);
    d_cyc = cyc + 1;
    wait_frames(3, 5000);
    step();
    chk("t2_first_rd_latency", first_rd_c[1] - d_cyc, 1);
    chk("t2_first_tvalid_latency", first_tv_c[1] - d_cyc, 3);
    chk("t2_no_gaps", tlast_c[1] - first_tv_c[1], FRAME_LEN - 1);
    chk("t2_min_gap", first_tv_c[2] - tlast_c[1], 4);
    chk("t2_frame_cnt", 32'(frame_cnt), 3);
    chk("t2_last_data", last_data, 32'h0000_17FF);

    // backpressure with ~30% tready
    rand_ready = 1;
    rd_base = rd_total;
    push_ramp(1024, 16'h2000);
    wait_frames(4, 20000);
    rand_ready = 0;
    m_axis_tready = 1'b1;
    repeat (3) step();
    chk("t3_read_count", rd_total - rd_base, 1024);
    chk("t3_frame_cnt", 32'(frame_cnt), 4);

    // en control: idle with en=0, drop en mid-frame
    en = 1'b0;
    push_ramp(4096, 16'h3000);
    rd_base = rd_total;
    repeat (30) step();
    chk("t4_idle_no_reads", rd_total - rd_base, 0);
    en = 1'b1;
    wait_beat(10, 200);
    en = 1'b0;
    wait_frames(5, 3000);
    repeat (50) step();
    chk("t4_one_frame_reads", rd_total - rd_base, 1024);
    chk("t4_frame_cnt", 32'(frame_cnt), 5);
    fifo_q.delete();
    exp_q.delete();
    flags();
    step();

    // underrun: empty forced mid-frame
    en = 1'b1;
    push_ramp(1024, 16'h4000);
    wait_beat(300, 1000);
    chk("t5_underrun_before", 32'(underrun), 0);
    force_empty = 1;
    flags();
    rd_base = rd_total;
    repeat (20) step();
    chk("t5_no_reads_while_empty", rd_total - rd_base, 0);
    chk("t5_underrun_set", 32'(underrun), 1);
    force_empty = 0;
    flags();
    done_base = done_cnt;
    wait_frames(6, 3000);
    repeat (5) step();
    chk("t5_underrun_sticky", 32'(underrun), 1);
    chk("t5_single_tlast", done_cnt - done_base, 1);
    chk("t5_last_data", last_data, 32'h0000_43FF);

    // reset mid-frame
    push_ramp(1024, 16'h6000);
    wait_beat(500, 1000);
    rst = 1'b1;
    #1 chk_zero_outputs("midreset");
    fifo_q.delete();
    exp_q.delete();
    exp_frames = 0;
    beat_idx = 0;
    rd_in_frame = 0;
    rd_total = 0;
    beats_total = 0;
    seen_first = 0;
    last_rd_en = 0;
    prev_stall = 0;
    flags();
    repeat (3) step();
    rst = 1'b0;
    push_ramp(1024, 16'h5000);
    wait_frames(1, 3000);
    step();
    chk("t6_frame_cnt", 32'(frame_cnt), 1);
    chk("t6_first_data", first_data, 32'h0000_5000);
    chk("t6_last_data", last_data, 32'h0000_53FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
